// File: rtl/saa_i2s_tx.sv
// Philips I2S transmitter for the SAA1099 mixer: converts two 8-bit offset-binary
// samples to left-justified 16-bit two's complement words and serialises them.
module saa_i2s_tx #(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] in_l,
    input  logic [7:0] in_r,
    output logic       i2s_bclk,
    output logic       i2s_lrclk,
    output logic       i2s_data,
    output logic       sample_ack
);

    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

    logic [7:0]  r_div_cnt;
    logic [4:0]  r_s;
    logic [31:0] r_sr;
    logic        r_bclk;
    logic        r_lrclk;
    logic        r_data;
    logic        r_ack;

    logic        w_tick;
    logic        w_fall;
    logic        w_load;
    logic [4:0]  w_s_next;
    logic [15:0] w_l16;
    logic [15:0] w_r16;
    logic [31:0] w_sr_next;

    assign w_tick   = (r_div_cnt == DIV_LAST);
    assign w_fall   = w_tick & r_bclk;
    // The 0->1 slot step is the only point where inputs are captured.
    assign w_load   = w_fall & (r_s == 5'd0);
    assign w_s_next = r_s + 5'd1;

    // Flipping the MSB turns offset-binary into two's complement.
    assign w_l16 = en ? {~in_l[7], in_l[6:0], 8'h00} : 16'h0000;
    assign w_r16 = en ? {~in_r[7], in_r[6:0], 8'h00} : 16'h0000;

    assign w_sr_next = w_load ? {w_l16, w_r16} : {r_sr[30:0], 1'b0};

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= 8'd0;
            r_s       <= 5'd0;
            r_sr      <= 32'd0;
            r_bclk    <= 1'b0;
            r_lrclk   <= 1'b0;
            r_data    <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_div_cnt <= w_tick ? 8'd0 : r_div_cnt + 8'd1;
            r_ack     <= w_load;
            if (w_tick) begin
                r_bclk <= ~r_bclk;
            end
            // Data follows the new shift-register MSB, giving the one-bclk I2S delay
            // relative to lrclk without a separate delay stage.
            if (w_fall) begin
                r_s     <= w_s_next;
                r_lrclk <= w_s_next[4];
                r_sr    <= w_sr_next;
                r_data  <= w_sr_next[31];
            end
        end
    end

    // sample_ack: single-cycle strobe, no handshake; the source must hold
    // in_l/in_r/en valid across the load edge and may change them any time after.
    assign i2s_bclk   = r_bclk;
    assign i2s_lrclk  = r_lrclk;
    assign i2s_data   = r_data;
    assign sample_ack = r_ack;

endmodule

// File: tb/tb_saa_i2s_tx.sv
// Bench for saa_i2s_tx: BCLK_DIV=4 instance checked by an I2S receiver and
// scoreboard, BCLK_DIV=1 instance checked for timing and one frame.
module tb_saa_i2s_tx;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] in_l;
    logic [7:0] in_r;
    logic       bclk, lrclk, data, ack;
    logic       en1;
    logic [7:0] l1, r1;
    logic       bclk1, lr1, data1, ack1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit sb_active = 1'b1;
    logic [16:0] exp_q[$];

    typedef struct {
        logic        en;
        logic [7:0]  l;
        logic [7:0]  r;
        logic [15:0] el;
        logic [15:0] er;
        int          dly;
    } vec_t;
    vec_t vecs[10];

    saa_i2s_tx #(.BCLK_DIV(4)) dut (
        .clk_sys(clk), .rst_n(rst_n), .en(en), .in_l(in_l), .in_r(in_r),
        .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_data(data), .sample_ack(ack)
    );

    saa_i2s_tx #(.BCLK_DIV(1)) dut1 (
        .clk_sys(clk), .rst_n(rst_n), .en(en1), .in_l(l1), .in_r(r1),
        .i2s_bclk(bclk1), .i2s_lrclk(lr1), .i2s_data(data1), .sample_ack(ack1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] conv(input logic e, input logic [7:0] x);
        logic [7:0] t;
        t = x ^ 8'h80;
        return e ? {t, 8'h00} : 16'h0000;
    endfunction

    // I2S receiver: sample on bclk rising; an lrclk change marks the LSB of the old word.
    logic        m_pb, m_plr;
    logic [15:0] m_sh;
    always @(negedge clk) begin
        logic [15:0] w;
        logic [16:0] e;
        if (!rst_n) begin
            m_pb = 1'b0; m_plr = 1'b0; m_sh = 16'h0;
        end else begin
            if (bclk && !m_pb) begin
                w = {m_sh[14:0], data};
                if (sb_active && lrclk != m_plr) begin
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", {15'd0, m_plr, w}, 32'h1ffff);
                    end else begin
                        e = exp_q.pop_front();
                        check(m_plr ? "right_word" : "left_word", {15'd0, m_plr, w}, {15'd0, e});
                    end
                end
                m_sh = w;
                m_plr = lrclk;
            end
            m_pb = bclk;
        end
    end

    // driver tasks
    task automatic wait_ack(input bit which, output int c);
        c = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if ((which ? ack1 : ack) === 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) check(which ? "ack1_timeout" : "ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic apply(input vec_t v);
        en = v.en; in_l = v.l; in_r = v.r;
        exp_q.push_back({1'b0, v.el});
        exp_q.push_back({1'b1, v.er});
    endtask

    task automatic capture1(output logic [31:0] d, output logic [31:0] lr);
        logic pb;
        int n;
        pb = bclk1; n = 0; d = 0; lr = 0;
        for (int k = 0; k < 200 && n < 32; k++) begin
            @(negedge clk);
            if (bclk1 && !pb) begin
                d = {d[30:0], data1};
                lr = {lr[30:0], lr1};
                n++;
            end
            pb = bclk1;
        end
        check("cap1_bits", n, 32);
    endtask

    initial begin
        int c_prev, c_now, c_rel, bad, r0, r1c;
        logic [31:0] d, lr;
        logic pb;
        vec_t rv;

        vecs[0] = '{1'b1, 8'hFF, 8'h00, 16'h7F00, 16'h8000, 5};
        vecs[1] = '{1'b1, 8'h80, 8'h80, 16'h0000, 16'h0000, 100};
        vecs[2] = '{1'b1, 8'h00, 8'h80, 16'h8000, 16'h0000, 200};
        vecs[3] = '{1'b0, 8'hC3, 8'h3C, 16'h0000, 16'h0000, 10};
        vecs[4] = '{1'b1, 8'h12, 8'h55, 16'h9200, 16'hD500, 32};
        vecs[5] = '{1'b1, 8'hAB, 8'hAA, 16'h2B00, 16'h2A00, 0};
        vecs[6] = '{1'b1, 8'h01, 8'h7F, 16'h8100, 16'hFF00, 50};
        for (int i = 7; i < 10; i++) begin
            rv.en = 1'b1;
            rv.l = 8'($urandom_range(0, 255));
            rv.r = 8'($urandom_range(0, 255));
            rv.el = conv(rv.en, rv.l);
            rv.er = conv(rv.en, rv.r);
            rv.dly = $urandom_range(0, 200);
            vecs[i] = rv;
        end

        rst_n = 1'b0; en = 1'b0; in_l = 8'h00; in_r = 8'h00;
        en1 = 1'b1; l1 = 8'hFF; r1 = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", {24'd0, bclk, lrclk, data, ack, bclk1, lr1, data1, ack1}, 32'd0);

        apply(vecs[0]);
        c_rel = cyc;
        rst_n = 1'b1;
        c_prev = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) apply(vecs[i]);
            wait_ack(1'b0, c_now);
            if (i == 0) check("first_ack_latency", c_now - c_rel, 8);
            else check("ack_period", c_now - c_prev, 256);
            c_prev = c_now;
            if (i < 9) repeat (vecs[i].dly) @(negedge clk);
        end

        // reset at slot 20 of the frame in flight
        repeat (155) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("midframe_reset_outputs", {28'd0, bclk, lrclk, data, ack}, 32'd0);
        exp_q.delete();
        rv = '{1'b1, 8'h3C, 8'hC3, 16'hBC00, 16'h4300, 0};
        apply(rv);
        repeat (3) @(negedge clk);
        c_rel = cyc;
        rst_n = 1'b1;
        wait_ack(1'b0, c_now);
        check("ack_after_reset", c_now - c_rel, 8);

        for (int k = 0; k < 1000 && exp_q.size() != 0; k++) @(negedge clk);
        sb_active = 1'b0;
        check("scoreboard_drained", exp_q.size(), 0);

        // BCLK_DIV=1 instance
        bad = 0;
        pb = bclk1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bclk1 == pb) bad++;
            pb = bclk1;
        end
        check("div1_bclk_toggle", bad, 0);
        wait_ack(1'b1, c_prev);
        capture1(d, lr);
        check("div1_frame_data", d, 32'h7F008000);
        check("div1_lrclk_slots", lr, 32'h0001FFFE);
        wait_ack(1'b1, c_now);
        check("div1_ack_period", c_now - c_prev, 64);

        r0 = -1; r1c = -1;
        pb = lr1;
        for (int k = 0; k < 300 && r1c < 0; k++) begin
            @(negedge clk);
            if (lr1 && !pb) begin
                if (r0 < 0) r0 = cyc; else r1c = cyc;
            end
            pb = lr1;
        end
        check("div1_lrclk_period", r1c - r0, 64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
